fpu_mul_exp_pipe: RTL and testbench
===================================

FPU_MUL_EXP_PIPE -- requirements
Module: fpu_mul_exp_pipe

Interface
REQ-001 SHALL have parameter EXPW, default 11: native exponent width, minimum 9.
REQ-002 SHALL have parameter DEPTH, default 3: number of pipeline stages, minimum 2.
REQ-003 SHALL have parameter TAGW, default 4: sideband tag width.
REQ-004 SHALL have port rclk, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_vld, input, 1 bit: request valid.
REQ-007 SHALL have port in_rdy, output, 1 bit: request accepted when in_vld & in_rdy.
REQ-008 SHALL have ports in_exp1 and in_exp2, input, EXPW bits each: biased operand exponents, narrow formats LSB-aligned.
REQ-009 SHALL have port in_fmt, input, 2 bits: 0 = native (fmuld), 1 = narrow 8-bit (fmuls), 2 = narrow-in/native-out (fsmuld), 3 = reserved, treated as 0.
REQ-010 SHALL have port in_lz, input, 7 bits: product leading-zero count.
REQ-011 SHALL have port in_inc, input, 1 bit: normalisation increment.
REQ-012 SHALL have port in_rnd_cout, input, 1 bit: rounding-adder carry out.
REQ-013 SHALL have port in_to_0, input, 1 bit: rounding mode toward zero on overflow.
REQ-014 SHALL have port in_tag, input, TAGW bits: opaque sideband.
REQ-015 SHALL have port out_vld, output, 1 bit: result valid.
REQ-016 SHALL have port out_rdy, input, 1 bit: consumer accepts result.
REQ-017 SHALL have port out_exp, output, EXPW bits: result exponent, narrow results LSB-aligned with upper bits 0.
REQ-018 SHALL have ports out_of and out_uf, output, 1 bit each: overflow flag and underflow (result <= 0) flag.
REQ-019 SHALL have port out_tag, output, TAGW bits: tag of the result.

Function
REQ-020 Bias SHALL be Bn = 2^(EXPW-1)-1 for native and Bs = 127 for narrow; Bin and Bout are selected by in_fmt.
REQ-021 Stage 1 SHALL register the raw sum S = e1 + e2 - 2*Bin + Bout as a signed value, EXPW+3 bits wide, with no intermediate truncation.
REQ-022 The final stage SHALL capture E = S - in_lz + in_inc + in_rnd_cout; the lz/inc/cout fields SHALL be registered alongside S through all stages.
REQ-023 If E >= Emax (all-ones of the output format), out_exp SHALL be Emax-1 when to_0=1, else Emax; out_of=1.
REQ-024 If E <= 0, out_exp SHALL be 0 and out_uf=1; otherwise out_exp = E[EXPW-1:0] and both flags 0.
REQ-025 Intermediate stages (2..DEPTH-1) SHALL pass data unchanged.
REQ-026 Latency SHALL be exactly DEPTH cycles from acceptance to out_vld when unstalled, with throughput of 1 request per cycle.
REQ-027 Stage k SHALL load when it is empty or stage k+1 loads (the last stage loads when it is empty or out_rdy=1); in_rdy = stage-1 load condition.
REQ-028 When out_vld=1 and out_rdy=0, out_exp, out_of, out_uf and out_tag SHALL hold stable; no request is dropped or duplicated, and ordering is preserved.
REQ-029 Simultaneous accept and retire on a full pipe SHALL proceed without a bubble.
REQ-030 The in_fmt=3 case SHALL behave as in_fmt=0.

Reset
REQ-031 While rst=1, all stage valid bits SHALL clear at the next rclk edge, with out_vld=0, out_exp=0, out_of=0, out_uf=0, out_tag=0.
REQ-032 in_rdy SHALL be 1 on the first cycle after rst deasserts.
REQ-033 Reset mid-operation SHALL discard all in-flight requests; no stale out_vld is permitted.

Structure
REQ-034 Package fpu_mul_exp_pkg SHALL hold the fmt encodings, the narrow bias (127), and the narrow exponent width (8).
REQ-035 The block SHALL use one sub-module, fpu_mul_exp_stage: a parametrised valid/data register slice with load enable and synchronous clear, instantiated DEPTH times.
REQ-036 All flops SHALL clock on rclk only.

Verification
REQ-037 fmt=0, exp1=0x400, exp2=0x3FF, lz=0, inc=0, cout=0 -> out_exp=0x400, flags 0, out_vld exactly 3 cycles after accept.
REQ-038 fmt=1, exp1=0x080, exp2=0x07F -> out_exp=0x080; fmt=2 with the same operands -> out_exp=0x400.
REQ-039 fmt=0, exp1=exp2=0x7FE -> out_exp=0x7FF with out_of=1; repeated with to_0=1 -> out_exp=0x7FE with out_of=1.
REQ-040 fmt=0, exp1=exp2=0x001 -> out_exp=0, out_uf=1; exp1=0x3FF, exp2=0x001, lz=1, inc=0 -> E=0 -> out_uf=1.
REQ-041 Back-to-back stream of 8 tags with out_rdy=0 for cycles 4-8 -> in_rdy=0 after 3 accepts; all 8 tags emerge in order, with no loss or duplication.
REQ-042 rst asserted with 2 requests in flight -> out_vld=0 on the following cycle and no stale output after deassert.

Source files
------------

// File: rtl/fpu_mul_exp_pkg.sv
// Shared format encodings and narrow-format constants for the multiply
// exponent pipeline.
package fpu_mul_exp_pkg;

  typedef enum logic [1:0] {
    FMT_NATIVE    = 2'd0,
    FMT_NARROW    = 2'd1,
    FMT_NARROW_IN = 2'd2,
    FMT_RSVD      = 2'd3
  } fmt_e;

  localparam int NARROW_BIAS = 127;
  localparam int NARROW_EXPW = 8;

  // Reserved encoding falls through both helpers as native.
  function automatic logic fmt_narrow_in(input fmt_e f);
    return (f == FMT_NARROW) || (f == FMT_NARROW_IN);
  endfunction

  function automatic logic fmt_narrow_out(input fmt_e f);
    return (f == FMT_NARROW);
  endfunction

endpackage

// File: rtl/fpu_mul_exp_stage.sv
// One valid/data register slice of the pipeline: loads on enable, clears
// both valid and data on synchronous reset.
module fpu_mul_exp_stage #(
  parameter int W = 8
) (
  input  logic         rclk,
  input  logic         rst,
  input  logic         load,
  input  logic         vld_in,
  input  logic [W-1:0] data_in,
  output logic         vld,
  output logic [W-1:0] data
);

  always_ff @(posedge rclk) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load) begin
      vld <= vld_in;
      // Bubbles leave the payload untouched to avoid needless toggling.
      if (vld_in) data <= data_in;
    end
  end

endmodule

// File: rtl/fpu_mul_exp_pipe.sv
// Multiply exponent pipeline: stage 1 forms the rebiased exponent sum, the
// last stage normalises/rounds it and flags overflow or underflow.
module fpu_mul_exp_pipe
  import fpu_mul_exp_pkg::*;
#(
  parameter int EXPW  = 11,
  parameter int DEPTH = 3,
  parameter int TAGW  = 4
) (
  input  logic            rclk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [EXPW-1:0] in_exp1,
  input  logic [EXPW-1:0] in_exp2,
  input  logic [1:0]      in_fmt,
  input  logic [6:0]      in_lz,
  input  logic            in_inc,
  input  logic            in_rnd_cout,
  input  logic            in_to_0,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [EXPW-1:0] out_exp,
  output logic            out_of,
  output logic            out_uf,
  output logic [TAGW-1:0] out_tag
);

  // Handshake: a transfer happens on a rclk edge where valid & ready are both
  // high; valid and its payload never change while valid=1 and ready=0, and
  // ready may depend combinationally on downstream ready (no valid->ready path).

  localparam int SW = EXPW + 3;
  localparam int EW = EXPW + 4;
  localparam logic signed [SW-1:0] BIAS_N = SW'((2 ** (EXPW - 1)) - 1);
  localparam logic signed [SW-1:0] BIAS_S = SW'(NARROW_BIAS);
  localparam logic signed [EW-1:0] EMAX_N = EW'((2 ** EXPW) - 1);
  localparam logic signed [EW-1:0] EMAX_S = EW'((2 ** NARROW_EXPW) - 1);

  typedef struct packed {
    logic signed [SW-1:0] s;
    logic [6:0]           lz;
    logic                 inc;
    logic                 cout;
    logic                 to_0;
    logic                 nout;
    logic [TAGW-1:0]      tag;
  } pay_t;

  typedef struct packed {
    logic [EXPW-1:0] exp;
    logic            of;
    logic            uf;
    logic [TAGW-1:0] tag;
  } res_t;

  fmt_e                 fmt;
  logic                 nin;
  logic                 nout;
  logic signed [SW-1:0] e1_x;
  logic signed [SW-1:0] e2_x;
  logic signed [SW-1:0] b_in;
  logic signed [SW-1:0] b_out;
  pay_t                 pay_in;

  assign fmt = fmt_e'(in_fmt);

  always_comb begin
    nin   = fmt_narrow_in(fmt);
    nout  = fmt_narrow_out(fmt);
    e1_x  = nin ? SW'(in_exp1[NARROW_EXPW-1:0]) : SW'(in_exp1);
    e2_x  = nin ? SW'(in_exp2[NARROW_EXPW-1:0]) : SW'(in_exp2);
    b_in  = nin  ? BIAS_S : BIAS_N;
    b_out = nout ? BIAS_S : BIAS_N;
    pay_in      = '0;
    pay_in.s    = e1_x + e2_x - b_in - b_in + b_out;
    pay_in.lz   = in_lz;
    pay_in.inc  = in_inc;
    pay_in.cout = in_rnd_cout;
    pay_in.to_0 = in_to_0;
    pay_in.nout = nout;
    pay_in.tag  = in_tag;
  end

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] vld_in;
  pay_t             pay_c [DEPTH];

  // A stage loads when empty or when the one after it is loading too.
  always_comb begin
    logic nxt;
    load = '0;
    nxt  = ~vld[DEPTH-1] | out_rdy;
    load[DEPTH-1] = nxt;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      nxt     = ~vld[k] | nxt;
      load[k] = nxt;
    end
  end

  assign in_rdy = load[0];
  assign vld_in = {vld[DEPTH-2:0], in_vld};
  assign pay_c[0] = pay_in;

  for (genvar k = 0; k < DEPTH - 1; k++) begin : g_pay
    logic [$bits(pay_t)-1:0] q;
    fpu_mul_exp_stage #(.W($bits(pay_t))) u_stage (
      .rclk    (rclk),
      .rst     (rst),
      .load    (load[k]),
      .vld_in  (vld_in[k]),
      .data_in (pay_c[k]),
      .vld     (vld[k]),
      .data    (q)
    );
    assign pay_c[k+1] = pay_t'(q);
  end

  pay_t                 p_last;
  logic signed [EW-1:0] e_val;
  logic signed [EW-1:0] e_max;
  res_t                 res_d;
  logic [$bits(res_t)-1:0] res_q;

  always_comb begin
    p_last = pay_c[DEPTH-1];
    e_val  = EW'(p_last.s) - EW'({1'b0, p_last.lz})
           + EW'({1'b0, p_last.inc}) + EW'({1'b0, p_last.cout});
    e_max  = p_last.nout ? EMAX_S : EMAX_N;
    res_d     = '0;
    res_d.tag = p_last.tag;
    if (e_val <= 0) begin
      res_d.uf = 1'b1;
    end else if (e_val >= e_max) begin
      res_d.of  = 1'b1;
      res_d.exp = p_last.to_0 ? EXPW'(e_max - 1) : EXPW'(e_max);
    end else begin
      res_d.exp = e_val[EXPW-1:0];
    end
  end

  fpu_mul_exp_stage #(.W($bits(res_t))) u_last (
    .rclk    (rclk),
    .rst     (rst),
    .load    (load[DEPTH-1]),
    .vld_in  (vld_in[DEPTH-1]),
    .data_in (res_d),
    .vld     (vld[DEPTH-1]),
    .data    (res_q)
  );

  res_t res_o;
  assign res_o   = res_t'(res_q);
  assign out_vld = vld[DEPTH-1];
  assign out_exp = res_o.exp;
  assign out_of  = res_o.of;
  assign out_uf  = res_o.uf;
  assign out_tag = res_o.tag;

endmodule

// File: tb/tb_fpu_mul_exp_pipe.sv
// Directed bench for fpu_mul_exp_pipe (EXPW=11, DEPTH=3, TAGW=4) with an
// expected-result queue checked in order at the output.
module tb_fpu_mul_exp_pipe;

  logic        rclk;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [10:0] in_exp1;
  logic [10:0] in_exp2;
  logic [1:0]  in_fmt;
  logic [6:0]  in_lz;
  logic        in_inc;
  logic        in_rnd_cout;
  logic        in_to_0;
  logic [3:0]  in_tag;
  logic        out_vld;
  logic        out_rdy;
  logic [10:0] out_exp;
  logic        out_of;
  logic        out_uf;
  logic [3:0]  out_tag;

  fpu_mul_exp_pipe #(.EXPW(11), .DEPTH(3), .TAGW(4)) dut (
    .rclk        (rclk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_exp1     (in_exp1),
    .in_exp2     (in_exp2),
    .in_fmt      (in_fmt),
    .in_lz       (in_lz),
    .in_inc      (in_inc),
    .in_rnd_cout (in_rnd_cout),
    .in_to_0     (in_to_0),
    .in_tag      (in_tag),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_exp     (out_exp),
    .out_of      (out_of),
    .out_uf      (out_uf),
    .out_tag     (out_tag)
  );

  // clock / reset
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_recv   = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [16:0] mk(input logic [10:0] e, input logic of, input logic uf,
                                     input logic [3:0] tag);
    return {e, of, uf, tag};
  endfunction

  // scoreboard: compare each retired result against the head of exp_q
  always begin
    @(negedge rclk);
    #2;
    if (!rst && out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 32'(exp_q.size()), 32'd1);
      end else begin
        check("result", 32'({out_exp, out_of, out_uf, out_tag}), 32'(exp_q.pop_front()));
        n_recv++;
      end
    end
  end

  // drivers: called on a negedge, return on the negedge after acceptance
  task automatic push_req(input logic [1:0] fmt, input logic [10:0] e1, input logic [10:0] e2,
                          input logic [6:0] lz, input logic inc, input logic cout,
                          input logic to0, input logic [3:0] tag,
                          input logic [10:0] x_exp, input logic x_of, input logic x_uf,
                          output int waits);
    waits       = 0;
    in_vld      = 1'b1;
    in_fmt      = fmt;
    in_exp1     = e1;
    in_exp2     = e2;
    in_lz       = lz;
    in_inc      = inc;
    in_rnd_cout = cout;
    in_to_0     = to0;
    in_tag      = tag;
    #1;
    while (!in_rdy && waits < 100) begin
      @(negedge rclk);
      #1;
      waits++;
    end
    if (!in_rdy) check("accept_timeout", 32'(in_rdy), 32'd1);
    else exp_q.push_back(mk(x_exp, x_of, x_uf, tag));
    @(negedge rclk);
  endtask

  task automatic idle();
    in_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge rclk);
      cyc++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(negedge rclk);
  endtask

  int          w;
  int          recv_base;
  logic [16:0] held;

  initial begin
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    in_exp1 = '0; in_exp2 = '0; in_fmt = '0; in_lz = '0;
    in_inc = 1'b0; in_rnd_cout = 1'b0; in_to_0 = 1'b0; in_tag = '0;
    repeat (2) @(negedge rclk);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_exp", 32'(out_exp), 32'd0);
    check("rst_out_of",  32'(out_of),  32'd0);
    check("rst_out_uf",  32'(out_uf),  32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 32'(in_rdy), 32'd1);
    @(negedge rclk);

    // latency of a lone request
    push_req(2'd0, 11'h400, 11'h3FF, 7'd0, 1'b0, 1'b0, 1'b0, 4'd1, 11'h400, 1'b0, 1'b0, w);
    idle();
    check("lat_cyc1", 32'(out_vld), 32'd0);
    @(negedge rclk);
    check("lat_cyc2", 32'(out_vld), 32'd0);
    @(negedge rclk);
    check("lat_cyc3", 32'(out_vld), 32'd1);
    wait_drain();

    // back-to-back directed vectors
    push_req(2'd1, 11'h080, 11'h07F, 7'd0, 1'b0, 1'b0, 1'b0, 4'd2,  11'h080, 1'b0, 1'b0, w);
    push_req(2'd2, 11'h080, 11'h07F, 7'd0, 1'b0, 1'b0, 1'b0, 4'd3,  11'h400, 1'b0, 1'b0, w);
    push_req(2'd0, 11'h7FE, 11'h7FE, 7'd0, 1'b0, 1'b0, 1'b0, 4'd4,  11'h7FF, 1'b1, 1'b0, w);
    push_req(2'd0, 11'h7FE, 11'h7FE, 7'd0, 1'b0, 1'b0, 1'b1, 4'd5,  11'h7FE, 1'b1, 1'b0, w);
    push_req(2'd0, 11'h001, 11'h001, 7'd0, 1'b0, 1'b0, 1'b0, 4'd6,  11'h000, 1'b0, 1'b1, w);
    push_req(2'd0, 11'h3FF, 11'h001, 7'd1, 1'b0, 1'b0, 1'b0, 4'd7,  11'h000, 1'b0, 1'b1, w);
    push_req(2'd3, 11'h400, 11'h3FF, 7'd0, 1'b0, 1'b0, 1'b0, 4'd8,  11'h400, 1'b0, 1'b0, w);
    push_req(2'd0, 11'h400, 11'h3FF, 7'd3, 1'b1, 1'b1, 1'b0, 4'd9,  11'h3FF, 1'b0, 1'b0, w);
    push_req(2'd1, 11'h0FF, 11'h0FF, 7'd0, 1'b0, 1'b0, 1'b0, 4'd10, 11'h0FF, 1'b1, 1'b0, w);
    push_req(2'd1, 11'h0FF, 11'h0FF, 7'd0, 1'b0, 1'b0, 1'b1, 4'd11, 11'h0FE, 1'b1, 1'b0, w);
    push_req(2'd0, 11'h7FF, 11'h3FF, 7'd0, 1'b0, 1'b0, 1'b0, 4'd12, 11'h7FF, 1'b1, 1'b0, w);
    push_req(2'd0, 11'h7FE, 11'h3FF, 7'd0, 1'b0, 1'b0, 1'b0, 4'd13, 11'h7FE, 1'b0, 1'b0, w);
    push_req(2'd0, 11'h3FF, 11'h001, 7'd0, 1'b0, 1'b0, 1'b0, 4'd14, 11'h001, 1'b0, 1'b0, w);
    push_req(2'd1, 11'h001, 11'h001, 7'd0, 1'b0, 1'b0, 1'b0, 4'd15, 11'h000, 1'b0, 1'b1, w);
    idle();
    wait_drain();

    // stall: fill the pipe with the consumer blocked, then release
    recv_base = n_recv;
    out_rdy = 1'b0;
    for (int t = 0; t < 3; t++)
      push_req(2'd0, 11'h400, 11'h3FF, 7'd0, 1'b0, 1'b0, 1'b0, 4'(t), 11'h400, 1'b0, 1'b0, w);
    in_vld = 1'b1;
    in_tag = 4'd3;
    #1;
    check("stall_in_rdy", 32'(in_rdy), 32'd0);
    check("stall_out_vld", 32'(out_vld), 32'd1);
    held = {out_exp, out_of, out_uf, out_tag};
    check("stall_head_tag", 32'(out_tag), 32'd0);
    @(negedge rclk);
    #1;
    check("stall_hold", 32'({out_exp, out_of, out_uf, out_tag}), 32'(held));
    check("stall_in_rdy2", 32'(in_rdy), 32'd0);
    @(negedge rclk);
    out_rdy = 1'b1;
    push_req(2'd0, 11'h400, 11'h3FF, 7'd0, 1'b0, 1'b0, 1'b0, 4'd3, 11'h400, 1'b0, 1'b0, w);
    check("full_no_bubble", 32'(w), 32'd0);
    for (int t = 4; t < 8; t++) begin
      push_req(2'd0, 11'h400, 11'h3FF, 7'd0, 1'b0, 1'b0, 1'b0, 4'(t), 11'h400, 1'b0, 1'b0, w);
      check("stream_no_wait", 32'(w), 32'd0);
    end
    idle();
    wait_drain();
    check("stream_count", 32'(n_recv - recv_base), 32'd8);

    // reset with two requests in flight
    push_req(2'd0, 11'h400, 11'h3FF, 7'd0, 1'b0, 1'b0, 1'b0, 4'hA, 11'h400, 1'b0, 1'b0, w);
    push_req(2'd0, 11'h400, 11'h3FF, 7'd0, 1'b0, 1'b0, 1'b0, 4'hB, 11'h400, 1'b0, 1'b0, w);
    idle();
    rst = 1'b1;
    exp_q.delete();
    @(negedge rclk);
    check("mid_rst_out_vld", 32'(out_vld), 32'd0);
    check("mid_rst_out_exp", 32'(out_exp), 32'd0);
    check("mid_rst_out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(in_rdy), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge rclk);
      check("no_stale_vld", 32'(out_vld), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
